// File: rtl/rv_pkg.sv
// Shared definitions for the fetch front end: widths, the fetch FSM encoding and
// the {pc, inst} buffer entry type.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // PCs advance by one word and wrap modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous instruction buffer holding {pc, inst} entries; clear has priority
// over push/pop and the head reads as zero while empty.
module if_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    input  logic         i_clear,
    output fetch_entry_t o_rdata,
    output logic [CW-1:0] o_count,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        do_pop  = i_pop && (count_q != '0);
        do_push = i_push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q];

    // Upstream credit accounting must never push into a full buffer without a pop.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_clear && full && !i_pop));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited in-order fetch, redirect flush and
// instruction buffer. Defining IF_PERF_CNT_EN adds saturating pop/redirect counters.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    // state | meaning
    // IDLE  | first cycle out of reset, nothing issued
    // FETCH | issuing requests and buffering responses
    // FLUSH | draining responses owed to requests made before a redirect
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          req;
    logic          hs;
    logic          credit_ok;
    logic          pop;
    logic          valid;
    logic          fifo_push;
    logic          fifo_clear;
    fetch_entry_t  fifo_wdata;
    fetch_entry_t  fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        fifo_wdata = '{pc: resp_pc_q, inst: i_imem_rdata};

        credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
        req        = (state_q == FETCH) && !i_redirect && credit_ok;
        hs         = req && i_imem_gnt;
        inflight_d = inflight_q + CW'(hs) - CW'(i_imem_rvalid);

        if (hs) begin
            pc_d = pc_next(pc_q);
        end

        if (i_imem_rvalid && (state_q == FETCH) && !i_redirect) begin
            fifo_push = 1'b1;
            resp_pc_d = pc_next(resp_pc_q);
        end

        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (i_redirect) begin
                    state_d = (inflight_d != '0) ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if (!i_redirect) begin
                    if (discard_q == '0) begin
                        state_d = FETCH;
                    end else if (i_imem_rvalid) begin
                        discard_d = discard_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Every response still owed at the end of a redirect cycle belongs to the wrong path.
        if (i_redirect) begin
            fifo_clear = 1'b1;
            pc_d       = pc_align(i_redirect_pc);
            resp_pc_d  = pc_align(i_redirect_pc);
            discard_d  = inflight_q - CW'(i_imem_rvalid);
        end

        valid = !fifo_empty && !i_redirect;
        pop   = valid && i_ready;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_wdata (fifo_wdata),
        .i_pop   (pop),
        .i_clear (fifo_clear),
        .o_rdata (fifo_head),
        .o_count (fifo_count),
        .o_empty (fifo_empty)
    );

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_valid     = valid;
    assign o_inst      = fifo_head.inst;
    assign o_pc        = fifo_head.pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pop && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (i_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule
